binary_to_tc_11: RTL and testbench
==================================

# binary_to_tc_11

Streaming binary-to-thermometer-code encoder for modulo-11 residues in the RNS modulo-adder datapath. It accepts a binary residue (0..10) on a valid/ready input and emits the 10-bit thermometer code on a valid/ready output. The output code feeds the thermometer-domain adder stages, and its encoding is bit-exact with the existing thermometer-to-binary decoder. A two-entry skid buffer gives full throughput with a registered `in_ready`.

## Interface
- `MOD`, default 11: residue modulus. Code width is `MOD-1` and input width is `$clog2(MOD)` (4 for 11).
- `CNT_W`, default 8: width of the out-of-range event counter.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset is synchronous and active-low.
- `in_valid` input, 1 bit: binary residue present.
- `in_ready` output, 1 bit: block can accept a beat. It is registered, not combinational from `out_ready`.
- `in_data` input, `$clog2(MOD)` bits: binary residue.
- `out_valid` output, 1 bit: thermometer code present.
- `out_ready` input, 1 bit: downstream accepts.
- `out_tc` output, `MOD-1` bits: thermometer code. Value k sets bits [k-1:0]; 0 gives all zeros.
- `out_err` output, 1 bit: the current output beat came from an out-of-range input. Constant 0 when the range check is compiled out.
- `err_cnt` output, `CNT_W` bits: saturating count of out-of-range beats accepted. Constant 0 when the range check is compiled out.

## Operation
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Encoding of an in-range value k (0..MOD-1): `out_tc[i] = (i < k)` for i = 0..MOD-2. Example: 3 → 10'b0000000111; 10 → 10'h3FF.
- Out-of-range input (k ≥ MOD, i.e. 11..15) is handled as described under Configuration.
- Buffering is a main register plus a skid register, with a three-state FSM:
  - EMPTY: `out_valid`=0, `in_ready`=1. On an input transfer, load main and go to ONE.
  - ONE: `out_valid`=1, `in_ready`=1.
    - Input transfer with no output transfer: load skid, go to FULL.
    - Input transfer and output transfer together: reload main, stay in ONE.
    - Output transfer only: go to EMPTY.
  - FULL: `out_valid`=1, `in_ready`=0. On an output transfer, move skid into main and go to ONE.
- Ordering is strict FIFO; no beat is dropped or duplicated.
- `out_tc` and `out_err` hold stable while `out_valid && !out_ready`.
- `err_cnt` increments on input transfer of an out-of-range value and saturates at all-ones.

## Timing
- Latency: an input accepted at edge N is visible on `out_tc`/`out_valid` after edge N (one cycle).
- Throughput: one beat per cycle while `out_ready` is held high.
- `in_ready` drops only after the skid register fills, so at most one extra beat is absorbed after `out_ready` falls.
- Reset (`rst_n`=0 at an edge) forces:
  - FSM to EMPTY;
  - `out_valid`=0, `in_ready`=1 (after the reset edge), `out_tc`=0, `out_err`=0, `err_cnt`=0.
- Reset asserted mid-stream discards both buffered beats. An input handshake in the reset cycle is ignored.
- Simultaneous input and output transfers in FULL cannot occur, because `in_ready`=0 in FULL.

## Configuration
- Macro `TC11_RANGE_CHECK_EN`.
- Defined:
  - Out-of-range inputs encode to all zeros, matching the decoder's default output.
  - `out_err`=1 travels with that beat.
  - `err_cnt` counts such beats.
- Undefined:
  - Out-of-range inputs saturate to all ones (10'h3FF).
  - `out_err` and `err_cnt` are tied to 0, with no error state registered.

## Structure
- Shared package `rns_tc_pkg` holds:
  - `MOD11` = 11, `TC11_W` = 10, `BIN11_W` = 4;
  - typedefs `tc11_t` and `bin11_t`;
  - the function `tc_encode(k)`, which the decoder testbench reuses.
- One sub-module, `tc_skid_buffer`: a parameterised-width two-entry valid/ready skid buffer holding {err, tc}.
- The top level does the encoding and range check before the buffer, and owns `err_cnt`.

## Test plan
- Sweep 0..10 with `out_ready`=1 → `out_tc` = 000, 001, 003 … 3FF in order, one cycle latency, no stalls.
- Hold `out_ready`=0 and push 4, then 7 → `in_ready` falls after the second beat and `out_tc`=00F holds. Raise `out_ready` → 00F then 07F, after which `in_ready` returns to 1.
- Input 13 with `TC11_RANGE_CHECK_EN` → `out_tc`=000, `out_err`=1, `err_cnt`=1. Without the macro → `out_tc`=3FF, `out_err`=0.
- Push 300 out-of-range beats (macro defined, `CNT_W`=8) → `err_cnt` saturates at 255.
- Reset while FULL → after the edge `out_valid`=0, `in_ready`=1, `out_tc`=0, and the next accepted value 2 emerges as 003.
- Random `in_valid`/`out_ready` over 10k beats → decoding `out_tc` through the existing decoder reproduces the input sequence exactly.

Source files
------------

// File: rtl/rns_tc_pkg.sv
// -----------------------------------------------------------------------------
// rns_tc_pkg
// Shared definitions for the modulo-11 thermometer-code datapath of the RNS
// modulo adder.
//   MOD11 / TC11_W / BIN11_W : modulus, code width and binary residue width
//   tc11_t / bin11_t         : thermometer code and binary residue types
//   skid_state_t             : state encoding of the two-entry skid buffer
//   tc_encode(k)             : reference thermometer encoder for the decoder
//                              bench (value k sets bits [k-1:0])
// -----------------------------------------------------------------------------
package rns_tc_pkg;

    localparam int MOD11   = 11;
    localparam int TC11_W  = 10;
    localparam int BIN11_W = 4;

    typedef logic [TC11_W-1:0]  tc11_t;
    typedef logic [BIN11_W-1:0] bin11_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    // Plain thermometer encoding. Any k at or above TC11_W lights every bit,
    // so out-of-range residues come out as all ones here.
    function automatic tc11_t tc_encode(input bin11_t k);
        tc11_t tc;
        tc = {TC11_W{1'b0}};
        for (int i = 0; i < TC11_W; i++) begin
            if (int'(k) > i) begin
                tc[i] = 1'b1;
            end else begin
                tc[i] = 1'b0;
            end
        end
        return tc;
    endfunction

endpackage

// File: rtl/tc_skid_buffer.sv
// -----------------------------------------------------------------------------
// tc_skid_buffer
// Two-entry valid/ready skid buffer (main register + skid register). Gives full
// throughput while keeping in_ready registered: in_ready falls only once the
// skid register holds a beat, so one extra beat is absorbed after out_ready
// drops.
//   W         : payload width
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset, discards buffered beats
//   in_valid  / in_ready  / in_data  : upstream handshake and payload
//   out_valid / out_ready / out_data : downstream handshake and payload
// -----------------------------------------------------------------------------
module tc_skid_buffer
    import rns_tc_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state_r;
    logic [W-1:0] main_r;
    logic [W-1:0] skid_r;
    logic         out_valid_r;
    logic         in_ready_r;
    logic         in_fire_s;
    logic         out_fire_s;

    assign in_fire_s  = in_valid && in_ready_r;
    assign out_fire_s = out_valid_r && out_ready;

    // Buffer FSM; handshake flags are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= SKID_EMPTY;
            main_r      <= {W{1'b0}};
            skid_r      <= {W{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                SKID_EMPTY: begin
                    if (in_fire_s) begin
                        main_r      <= in_data;
                        out_valid_r <= 1'b1;
                        state_r     <= SKID_ONE;
                    end else begin
                        state_r     <= SKID_EMPTY;
                    end
                end
                SKID_ONE: begin
                    if (in_fire_s && !out_fire_s) begin
                        // Downstream stalled: park the new beat in skid.
                        skid_r     <= in_data;
                        in_ready_r <= 1'b0;
                        state_r    <= SKID_FULL;
                    end else if (in_fire_s && out_fire_s) begin
                        main_r  <= in_data;
                        state_r <= SKID_ONE;
                    end else if (out_fire_s) begin
                        out_valid_r <= 1'b0;
                        state_r     <= SKID_EMPTY;
                    end else begin
                        state_r <= SKID_ONE;
                    end
                end
                SKID_FULL: begin
                    if (out_fire_s) begin
                        main_r     <= skid_r;
                        in_ready_r <= 1'b1;
                        state_r    <= SKID_ONE;
                    end else begin
                        state_r <= SKID_FULL;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= SKID_EMPTY;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;

endmodule

// File: rtl/binary_to_tc_11.sv
// -----------------------------------------------------------------------------
// binary_to_tc_11
// Streaming binary-to-thermometer encoder for modulo-11 residues. The encoding
// and range check sit in front of a two-entry skid buffer; this level also
// owns the out-of-range event counter.
// Parameters set the modulus (code width is modulus-1) and error counter width.
//   clk, rst_n : clock and synchronous active-low reset
//   in_valid / in_ready / in_data : binary residue input
//   out_valid / out_ready / out_tc : thermometer code output
//   out_err    : beat came from an out-of-range residue
//   err_cnt    : saturating count of accepted out-of-range residues
// Build option TC11_RANGE_CHECK_EN:
//   defined   - out-of-range residues encode to all zeros, flagged by out_err
//               and counted in err_cnt
//   undefined - out-of-range residues saturate to all ones; out_err and
//               err_cnt are tied low
// -----------------------------------------------------------------------------
module binary_to_tc_11
    import rns_tc_pkg::*;
#(
    parameter int MOD   = MOD11,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(MOD)-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MOD-2:0]           out_tc,
    output logic                     out_err,
    output logic [CNT_W-1:0]         err_cnt
);

    localparam int                TC_W   = MOD - 1;
    localparam int                IN_W   = $clog2(MOD);
    localparam logic [IN_W-1:0]   MAX_IN = IN_W'(MOD - 1);

`ifdef TC11_RANGE_CHECK_EN
    // Matches the decoder's default output for illegal codes.
    localparam logic [TC_W-1:0]   OOR_FILL = {TC_W{1'b0}};
    localparam int                PAY_W    = TC_W + 1;
`else
    localparam logic [TC_W-1:0]   OOR_FILL = {TC_W{1'b1}};
    localparam int                PAY_W    = TC_W;
`endif

    logic             oor_s;
    logic [TC_W-1:0]  thermo_s;
    logic [TC_W-1:0]  tc_s;
    logic [PAY_W-1:0] pay_in_s;
    logic [PAY_W-1:0] pay_out_s;

    // Thermometer encoding: bit i is set when the residue exceeds i.
    always_comb begin
        thermo_s = {TC_W{1'b0}};
        for (int i = 0; i < TC_W; i++) begin
            if (int'(in_data) > i) begin
                thermo_s[i] = 1'b1;
            end else begin
                thermo_s[i] = 1'b0;
            end
        end
    end

    assign oor_s = (in_data > MAX_IN);
    assign tc_s  = oor_s ? OOR_FILL : thermo_s;

`ifdef TC11_RANGE_CHECK_EN
    logic [CNT_W-1:0] err_cnt_r;

    assign pay_in_s = {oor_s, tc_s};
    assign out_err  = pay_out_s[TC_W];
    assign out_tc   = pay_out_s[TC_W-1:0];
    assign err_cnt  = err_cnt_r;

    // Out-of-range event counter, saturating at all ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_r <= {CNT_W{1'b0}};
        end else if (in_valid && in_ready && oor_s &&
                     (err_cnt_r != {CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end
`else
    assign pay_in_s = tc_s;
    assign out_err  = 1'b0;
    assign out_tc   = pay_out_s;
    assign err_cnt  = {CNT_W{1'b0}};
`endif

    tc_skid_buffer #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out_s)
    );

endmodule

// File: tb/tb_binary_to_tc_11.sv
// -----------------------------------------------------------------------------
// tb_binary_to_tc_11
// Self-checking bench for binary_to_tc_11 (MOD=11, CNT_W=8). Accepted inputs
// are queued on the input handshake and compared on the output handshake;
// scenario tasks add direct checks of latency, stall, range and reset.
// Expectations follow TC11_RANGE_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_binary_to_tc_11;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_tc;
    logic       out_err;
    logic [7:0] err_cnt;

    int         checks;
    int         errors;
    int         pushes;
    int         exp_cnt;
    logic [3:0] sb[$];
    logic       stall_seen;
    logic [9:0] stall_tc;
    logic       stall_err;

    binary_to_tc_11 #(.MOD(11), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tc    (out_tc),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] exp_tc(input logic [3:0] k);
        logic [10:0] t;
        if (k > 4'd10) begin
`ifdef TC11_RANGE_CHECK_EN
            return 10'h000;
`else
            return 10'h3FF;
`endif
        end
        t = (11'd1 << k) - 11'd1;
        return t[9:0];
    endfunction

    function automatic logic exp_err(input logic [3:0] k);
`ifdef TC11_RANGE_CHECK_EN
        return (k > 4'd10);
`else
        return (k != k);
`endif
    endfunction

    // One clock: score handshakes at the falling edge, then advance past the
    // next rising edge so the caller can drive new inputs.
    task automatic step();
        logic [3:0] k;
        @(negedge clk);
        if (rst_n) begin
            if (stall_seen) begin
                checks++;
                if (out_valid !== 1'b1 || out_tc !== stall_tc || out_err !== stall_err) begin
                    errors++;
                    $display("FAIL hold: valid=%b tc=%h err=%b, required valid=1 tc=%h err=%b",
                             out_valid, out_tc, out_err, stall_tc, stall_err);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_beat: tc=%h with nothing expected", out_tc);
                end else begin
                    k = sb.pop_front();
                    if (out_tc !== exp_tc(k) || out_err !== exp_err(k)) begin
                        errors++;
                        $display("FAIL scoreboard: in=%0d tc=%h err=%b, required tc=%h err=%b",
                                 k, out_tc, out_err, exp_tc(k), exp_err(k));
                    end
                end
            end
            stall_seen = (out_valid === 1'b1) && !out_ready;
            stall_tc   = out_tc;
            stall_err  = out_err;
            if (in_valid && in_ready === 1'b1) begin
                sb.push_back(in_data);
                pushes++;
`ifdef TC11_RANGE_CHECK_EN
                if (in_data > 4'd10 && exp_cnt < 255) exp_cnt++;
`endif
            end
        end else begin
            stall_seen = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats left, required 0", sb.size());
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_tc !== 10'h000 ||
            out_err !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL %s: valid=%b ready=%b tc=%h err=%b cnt=%0d, required 0 1 000 0 0",
                     name, out_valid, in_ready, out_tc, out_err, err_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 4'd3; out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        sb.delete(); exp_cnt = 0;
        check_idle("reset");
    endtask

    task automatic test_sweep();
        out_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            in_valid = 1'b1;
            in_data  = 4'(k);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL sweep_ready: in_ready=%b at k=%0d, required 1", in_ready, k);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_tc !== exp_tc(4'(k))) begin
                errors++;
                $display("FAIL sweep_latency: k=%0d valid=%b tc=%h, required 1 %h",
                         k, out_valid, out_tc, exp_tc(4'(k)));
            end
        end
        drain();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'd4;
        step();
        in_data = 4'd7;
        step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_tc !== 10'h00F) begin
            errors++;
            $display("FAIL stall_full: in_ready=%b tc=%h, required 0 00f", in_ready, out_tc);
        end
        step(); step(); step();
        out_ready = 1'b1;
        step();
        checks++;
        if (out_tc !== 10'h07F || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: tc=%h in_ready=%b valid=%b, required 07f 1 1",
                     out_tc, in_ready, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_empty: valid=%b, required 0", out_valid);
        end
        drain();
    endtask

    task automatic test_range();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'd13;
        step();
        in_valid = 1'b0;
        checks++;
`ifdef TC11_RANGE_CHECK_EN
        if (out_tc !== 10'h000 || out_err !== 1'b1 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL range: tc=%h err=%b cnt=%0d, required 000 1 1", out_tc, out_err, err_cnt);
        end
`else
        if (out_tc !== 10'h3FF || out_err !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL range: tc=%h err=%b cnt=%0d, required 3ff 0 0", out_tc, out_err, err_cnt);
        end
`endif
        drain();
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(11 + (i % 5));
            step();
        end
        drain();
        checks++;
`ifdef TC11_RANGE_CHECK_EN
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL saturate: cnt=%0d, required 255", err_cnt);
        end
`else
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL saturate: cnt=%0d, required 0", err_cnt);
        end
`endif
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'd1;
        step();
        in_data = 4'd6;
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_full_pre: in_ready=%b, required 0", in_ready);
        end
        rst_n = 1'b0; in_data = 4'd5;
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        sb.delete(); exp_cnt = 0;
        check_idle("reset_full");
        in_valid = 1'b1; in_data = 4'd2; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tc !== 10'h003) begin
            errors++;
            $display("FAIL reset_full_next: valid=%b tc=%h, required 1 003", out_valid, out_tc);
        end
        drain();
    endtask

    task automatic test_random();
        int start;
        int cycles;
        start  = pushes;
        cycles = 0;
        while ((pushes - start) < 10000 && cycles < 40000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom_range(0, 10));
            out_ready = ($urandom_range(0, 2) != 0);
            step();
            cycles++;
        end
        checks++;
        if ((pushes - start) < 10000) begin
            errors++;
            $display("FAIL random_budget: %0d beats accepted, required 10000", pushes - start);
        end
        drain();
        checks++;
        if (err_cnt !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL random_cnt: cnt=%0d, required %0d", err_cnt, exp_cnt);
        end
    endtask

    initial begin
        checks = 0; errors = 0; pushes = 0; exp_cnt = 0;
        stall_seen = 1'b0; stall_tc = 10'h000; stall_err = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
        test_reset();
        test_sweep();
        test_stall();
        test_range();
        test_saturate();
        test_reset_full();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
